// File: rtl/gps_sample_pkg.sv
// gps_sample_pkg: shared constants and FSM state type for the GPS sample
// capture buffer. Optional circular capture is selected by GPS_SAMPLE_WRAP_EN.
package gps_sample_pkg;

    localparam int GPS_WORD_W     = 16;
    localparam int GPS_DEPTH_LOG2 = 13;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/gps_sample_ram.sv
// gps_sample_ram: simple dual-port synchronous RAM, one write port and one
// registered read port. Read-first: a read and write to the same address on
// the same edge returns the old contents. The read register clears on rst.
module gps_sample_ram
    import gps_sample_pkg::*;
#(
    parameter int ADDR_W = GPS_DEPTH_LOG2,
    parameter int DATA_W = GPS_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; non-blocking update gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gps_sample_capture.sv
// gps_sample_capture: packs 1-bit GPS sign samples MSB-first into 16-bit words
// and stores them in block RAM for host read-back over dout.
// Build option GPS_SAMPLE_WRAP_EN: circular capture, frozen by the first rd
// after full, with the read pointer moved to the oldest word.
module gps_sample_capture
    import gps_sample_pkg::*;
#(
    parameter int DEPTH_LOG2 = GPS_DEPTH_LOG2,
    parameter int WORD_W     = GPS_WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  rd,
    output logic [WORD_W-1:0]     dout,
    output logic                  full,
    output logic [DEPTH_LOG2-1:0] wptr
);

    state_t                state, state_nxt;
    logic [WORD_W-2:0]     sreg;
    logic [3:0]            bcnt;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2-1:0] raddr;
    logic                  we;
    logic                  freeze;
    logic                  capture;
    logic [WORD_W-1:0]     wdata;

    assign wdata = {sreg, din};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, capture/write enables and precomputed read address.
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        freeze    = 1'b0;
        capture   = 1'b0;
        raddr     = rd ? rptr + DEPTH_LOG2'(1) : rptr;
        if (!rst) begin
            case (state)
                FILL: begin
`ifdef GPS_SAMPLE_WRAP_EN
                    // Freezing rd takes no sample and reads the oldest word.
                    if (full && rd) begin
                        freeze    = 1'b1;
                        raddr     = wptr;
                        state_nxt = DONE;
                    end else begin
                        capture = 1'b1;
                        we      = (bcnt == 4'hF);
                    end
`else
                    capture = 1'b1;
                    we      = (bcnt == 4'hF);
                    if (we && (wptr == '1)) begin
                        state_nxt = DONE;
                    end
`endif
                end
                DONE: ;
            endcase
        end
    end

    // Packing shift register, bit/word counters, read pointer and full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            bcnt <= '0;
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            if (capture) begin
                sreg <= wdata[WORD_W-2:0];
                bcnt <= bcnt + 4'd1;
            end
            if (we) begin
                wptr <= wptr + DEPTH_LOG2'(1);
                if (wptr == '1) begin
                    full <= 1'b1;
                end
            end
            if (freeze) begin
                rptr <= wptr;
            end else if (rd) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
        end
    end

    gps_sample_ram #(
        .ADDR_W(DEPTH_LOG2),
        .DATA_W(WORD_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wptr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(dout)
    );

endmodule
